// File: rtl/lcd_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_reader: HD44780 4-bit mode read controller (BF/AC or data byte),     |
// | with optional busy-flag polling until BF clears or a poll limit is hit.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_reader #(
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 800,
  parameter int EN_LOW_CYC  = 800,
  parameter int MAX_POLLS   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [3:0] lcd_d_in
);

  localparam int c_MAX_CYC =
    (SETUP_CYC > EN_HIGH_CYC) ? ((SETUP_CYC > EN_LOW_CYC) ? SETUP_CYC : EN_LOW_CYC)
                              : ((EN_HIGH_CYC > EN_LOW_CYC) ? EN_HIGH_CYC : EN_LOW_CYC);
  localparam int c_PH_W = $clog2(c_MAX_CYC) + 1;

  localparam logic [c_PH_W-1:0] c_SETUP_LD = c_PH_W'(SETUP_CYC - 1);
  localparam logic [c_PH_W-1:0] c_HIGH_LD  = c_PH_W'(EN_HIGH_CYC - 1);
  localparam logic [c_PH_W-1:0] c_LOW_LD   = c_PH_W'(EN_LOW_CYC - 1);
  localparam logic [c_PH_W-1:0] c_PH_ONE   = c_PH_W'(1);
  localparam logic [16:0]       c_MAX_P    = 17'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_HI_EN  = 3'd2,
    S_HI_GAP = 3'd3,
    S_LO_EN  = 3'd4,
    S_LO_GAP = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t              r_state;
  logic [c_PH_W-1:0]   r_phase;
  logic [15:0]         r_polls;
  logic                r_poll;

  logic [16:0] w_reads;
  logic        w_phase_end;
  logic        w_bf_limit_ok;
  logic        w_again;
  logic        w_tmo;

  // Read-count including the one finishing now; BF comes from the high nibble.
  assign w_reads       = {1'b0, r_polls} + 17'd1;
  assign w_phase_end   = (r_phase == '0);
  assign w_bf_limit_ok = (w_reads < c_MAX_P);
  assign w_again       = r_poll & rd_data[7] & w_bf_limit_ok;
  assign w_tmo         = r_poll & rd_data[7] & ~w_bf_limit_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_polls <= '0;
      r_poll  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      rd_data <= 8'h00;
      lcd_rs  <= 1'b0;
      lcd_rw  <= 1'b0;
      lcd_en  <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_poll  <= poll;
            r_polls <= '0;
            busy    <= 1'b1;
            lcd_rw  <= 1'b1;
            lcd_rs  <= poll ? 1'b0 : rs_sel;
            r_phase <= c_SETUP_LD;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_phase_end) begin
            lcd_en  <= 1'b1;
            r_phase <= c_HIGH_LD;
            r_state <= S_HI_EN;
          end else begin
            r_phase <= r_phase - c_PH_ONE;
          end
        end
        S_HI_EN: begin
          if (w_phase_end) begin
            rd_data[7:4] <= lcd_d_in;
            lcd_en       <= 1'b0;
            r_phase      <= c_LOW_LD;
            r_state      <= S_HI_GAP;
          end else begin
            r_phase <= r_phase - c_PH_ONE;
          end
        end
        S_HI_GAP: begin
          if (w_phase_end) begin
            lcd_en  <= 1'b1;
            r_phase <= c_HIGH_LD;
            r_state <= S_LO_EN;
          end else begin
            r_phase <= r_phase - c_PH_ONE;
          end
        end
        S_LO_EN: begin
          if (w_phase_end) begin
            rd_data[3:0] <= lcd_d_in;
            lcd_en       <= 1'b0;
            r_phase      <= c_LOW_LD;
            r_state      <= S_LO_GAP;
          end else begin
            r_phase <= r_phase - c_PH_ONE;
          end
        end
        S_LO_GAP: begin
          if (w_phase_end) begin
            r_polls <= w_reads[15:0];
            // A repeat poll re-strobes directly: RS/RW are already set up,
            // so each extra iteration costs exactly one nibble pair.
            if (w_again) begin
              lcd_en  <= 1'b1;
              r_phase <= c_HIGH_LD;
              r_state <= S_HI_EN;
            end else begin
              done    <= 1'b1;
              timeout <= w_tmo;
              busy    <= 1'b0;
              lcd_rw  <= 1'b0;
              lcd_rs  <= 1'b0;
              r_phase <= '0;
              r_state <= S_FINISH;
            end
          end else begin
            r_phase <= r_phase - c_PH_ONE;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lcd_reader.md
# lcd_reader

Read-side controller for the HD44780-compatible character LCD in 4-bit mode. It performs one 8-bit read as two nibble strobes on D7..D4 with RW=1. A read returns either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM byte (RS=1). An optional busy-flag poll mode repeats RS=0 reads until BF clears, so the LCD write sequencer can replace fixed post-command delays with a true ready check.

## Interface
Parameters:
- SETUP_CYC, 4: cycles RS/RW are held stable with EN low before each transaction (tAS).
- EN_HIGH_CYC, 800: cycles EN is high per nibble strobe.
- EN_LOW_CYC, 800: cycles EN is low after each nibble strobe.
- MAX_POLLS, 255: maximum number of reads in poll mode before timeout; range 1..65535.

Ports:
- clk  in  1  system clock (Sys_Clk0).
- rst_n  in  1  synchronous, active-low reset.
- req  in  1  start request; accepted only in IDLE.
- rs_sel  in  1  register select for a single read: 0 = BF/address, 1 = data.
- poll  in  1  sampled with req; 1 = poll BF until clear, and rs_sel is ignored.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  one-cycle pulse coincident with done when the poll limit is hit.
- rd_data  out  8  last byte read: {high nibble, low nibble}.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  LCD RW; 1 only during a transaction. The top level tri-states its D7..D4 drivers while this is 1.
- lcd_en  out  1  LCD enable strobe.
- lcd_d_in  in  4  D7..D4 read from the pad.

## Operation
- States: IDLE, SETUP, HI_EN (high-nibble strobe), HI_GAP, LO_EN (low-nibble strobe), LO_GAP, FINISH.
- IDLE: if req=1, latch rs_sel and poll, set lcd_rw=1, set lcd_rs = (poll ? 0 : rs_sel), and go to SETUP.
- SETUP: lcd_en=0 for SETUP_CYC cycles, then go to HI_EN.
- HI_EN: lcd_en=1 for EN_HIGH_CYC cycles. On the last high cycle, sample lcd_d_in into rd_data[7:4].
- HI_GAP: lcd_en=0 for EN_LOW_CYC cycles.
- LO_EN: lcd_en=1 for EN_HIGH_CYC cycles. On the last high cycle, sample lcd_d_in into rd_data[3:0].
- LO_GAP: lcd_en=0 for EN_LOW_CYC cycles, then go to FINISH.
- FINISH, single read: done=1, lcd_rw=0, lcd_rs=0, busy=0, next state IDLE.
- FINISH, poll mode, rd_data[7]=0: done=1, return to IDLE.
- FINISH, poll mode, BF=1 and poll count < MAX_POLLS: increment the count and go to HI_EN. There is no new SETUP because RS/RW are unchanged. done stays 0.
- FINISH, poll mode, BF=1 and count = MAX_POLLS: done=1 and timeout=1, return to IDLE. rd_data holds the last read.
- Poll counter: 16 bits, cleared on acceptance, counts completed reads.
- Phase counter: a single down-counter reloaded at every state entry. Its width is clog2 of the largest of SETUP_CYC, EN_HIGH_CYC and EN_LOW_CYC, plus 1.
- rd_data changes only on nibble sample cycles and holds between transactions.

## Timing
- Reset values: busy=0, done=0, timeout=0, rd_data=8'h00, lcd_rs=0, lcd_rw=0, lcd_en=0, state IDLE, all counters 0.
- Reset mid-transaction: on the reset edge lcd_en and lcd_rw drop to 0 and no done is produced.
- Latency, single read: req is sampled at edge T, busy=1 from T+1, and done is high during cycle T + 1 + SETUP_CYC + 2*(EN_HIGH_CYC + EN_LOW_CYC).
- Each extra poll iteration adds 2*(EN_HIGH_CYC + EN_LOW_CYC) cycles.
- Handshake: req is level-sampled only in IDLE. req asserted while busy=1, including the FINISH cycle, is ignored and not queued. req held high continuously starts a new read on the first IDLE cycle after done.
- lcd_rs and lcd_rw never change while lcd_en=1.
- lcd_rw falls in the same cycle done rises.
- EN_HIGH_CYC=800 at the 10 MHz Sys_Clk0 gives 80 us, well above the 450 ns minimum PWEH.

## Test plan
- SETUP=2, H=3, L=3. Single read with rs_sel=1, LCD model drives 4'h4 then 4'h1 -> rd_data=8'h41, done exactly 15 cycles after req, lcd_rs=1 throughout, 2 EN pulses of 3 cycles each.
- Single read with rs_sel=0, model returns BF/AC = 8'h8A -> rd_data=8'h8A, lcd_rs=0, timeout=0.
- Poll mode, model reports BF=1 for 3 reads and then 8'h05 -> 4 reads with 8 EN pulses, rd_data=8'h05, done with timeout=0, and only one SETUP phase.
- Poll mode, MAX_POLLS=2, BF stuck at 1 (8'hFF) -> 2 reads, done and timeout pulse together, rd_data=8'hFF, lcd_rw=0 afterward.
- rst_n low during HI_EN of a read -> lcd_en=0 and lcd_rw=0 on that edge, all outputs at reset values, no done. A following read completes normally.
- req pulsed during busy and during the FINISH cycle -> ignored. Exactly one done per accepted request, and busy never re-asserts without a new IDLE-sampled req.
